// File: rtl/pio_led_sequencer_if.sv
// rtl/pio_led_sequencer_if.sv - Avalon-MM bus between the LED sequencer and the LED PIO slave
interface pio_led_sequencer_if;
    logic [2:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;

    modport master (
        output m_address,
        output m_chipselect,
        output m_write_n,
        output m_writedata,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_chipselect,
        input  m_write_n,
        input  m_writedata,
        output m_readdata
    );
endinterface

// File: rtl/pio_led_sequencer.sv
// rtl/pio_led_sequencer.sv - autonomous LED PIO pattern sequencer; optional readback via PIO_LED_SEQ_READBACK_EN
module pio_led_sequencer #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    input  logic [3:0]                 hold_value,
    pio_led_sequencer_if.master        bus,
    output logic                       busy,
    output logic                       step_pulse,
    output logic [3:0]                 cur_pattern,
    output logic                       mismatch,
    output logic [7:0]                 err_count
);

    localparam logic [2:0]  ADDR_DATA   = 3'd0;
    localparam logic [2:0]  ADDR_DIR    = 3'd1;
    localparam logic [2:0]  ADDR_OUTCLR = 3'd5;
    localparam logic [31:0] RELOAD      = TICK_DIV - 32'd1;

    localparam logic [1:0]  MODE_WALK  = 2'd0;
    localparam logic [1:0]  MODE_BLINK = 2'd1;
    localparam logic [1:0]  MODE_COUNT = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        DIR,
        STEP,
        WAIT,
        RB_REQ,
        RB_CHK,
        CLR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] period_cnt;
    logic [1:0]  last_mode;
    logic        first_step;
    logic [3:0]  next_pattern;

    // Pattern to emit at the next STEP: restart value after enable or a mode change, else advance
    always_comb begin
        next_pattern = 4'h0;
        if (first_step || (mode != last_mode)) begin
            case (mode)
                MODE_WALK:  next_pattern = 4'h1;
                MODE_BLINK: next_pattern = 4'hF;
                MODE_COUNT: next_pattern = 4'h0;
                default:    next_pattern = hold_value;
            endcase
        end else begin
            case (mode)
                MODE_WALK:  next_pattern = {cur_pattern[2:0], cur_pattern[3]};
                MODE_BLINK: next_pattern = ~cur_pattern;
                MODE_COUNT: next_pattern = cur_pattern + 4'd1;
                default:    next_pattern = hold_value;
            endcase
        end
    end

    // Next-state and bus/strobe decode; every write is a single idle-free cycle
    always_comb begin
        state_next           = state;
        bus.m_address        = ADDR_DATA;
        bus.m_chipselect     = 1'b0;
        bus.m_write_n        = 1'b1;
        bus.m_writedata      = 32'd0;
        step_pulse           = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = DIR;
                end
            end
            DIR: begin
                bus.m_address    = ADDR_DIR;
                bus.m_chipselect = 1'b1;
                bus.m_write_n    = 1'b0;
                bus.m_writedata  = 32'h0000_000F;
                state_next       = STEP;
            end
            STEP: begin
                bus.m_address    = ADDR_DATA;
                bus.m_chipselect = 1'b1;
                bus.m_write_n    = 1'b0;
                bus.m_writedata  = {28'd0, next_pattern};
                step_pulse       = 1'b1;
`ifdef PIO_LED_SEQ_READBACK_EN
                state_next       = RB_REQ;
`else
                state_next       = WAIT;
`endif
            end
`ifdef PIO_LED_SEQ_READBACK_EN
            RB_REQ: begin
                // Read request only: chipselect with write strobe inactive
                bus.m_address    = ADDR_DATA;
                bus.m_chipselect = 1'b1;
                state_next       = RB_CHK;
            end
            RB_CHK: begin
                state_next = WAIT;
            end
`endif
            WAIT: begin
                if (!enable) begin
                    state_next = CLR;
                end else if (period_cnt == 32'd1) begin
                    state_next = STEP;
                end
            end
            CLR: begin
                bus.m_address    = ADDR_OUTCLR;
                bus.m_chipselect = 1'b1;
                bus.m_write_n    = 1'b0;
                bus.m_writedata  = 32'h0000_000F;
                state_next       = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Period counter: loaded on each pattern write, counts down through readback and wait cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt <= 32'd0;
        end else if (state == STEP) begin
            period_cnt <= RELOAD;
        end else if ((state == WAIT || state == RB_REQ || state == RB_CHK) && period_cnt != 32'd0) begin
            period_cnt <= period_cnt - 32'd1;
        end
    end

    // Pattern history: DIR arms a restart, STEP records the value and mode actually written
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_pattern <= 4'h0;
            last_mode   <= 2'd0;
            first_step  <= 1'b1;
        end else if (state == DIR) begin
            first_step  <= 1'b1;
        end else if (state == STEP) begin
            cur_pattern <= next_pattern;
            last_mode   <= mode;
            first_step  <= 1'b0;
        end
    end

`ifdef PIO_LED_SEQ_READBACK_EN
    logic unused_readdata;
    assign unused_readdata = ^bus.m_readdata[31:4];

    // Readback compare: sticky flag plus saturating error counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mismatch  <= 1'b0;
            err_count <= 8'd0;
        end else if (state == RB_CHK && bus.m_readdata[3:0] != cur_pattern) begin
            mismatch <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`else
    logic unused_readdata;
    assign unused_readdata = ^bus.m_readdata;
    assign mismatch        = 1'b0;
    assign err_count       = 8'd0;
`endif

endmodule

// File: tb/tb_pio_led_sequencer.sv
// tb/tb_pio_led_sequencer.sv - randomized self-checking bench for pio_led_sequencer
module tb_pio_led_sequencer;

    localparam int TICK = 4;
    localparam logic [3:0] STUCK_MASK = 4'b1011;

`ifdef PIO_LED_SEQ_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    localparam int K_IDLE = 0;
    localparam int K_DIR  = 1;
    localparam int K_STEP = 2;
    localparam int K_RUN  = 3;
    localparam int K_CLR  = 4;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [1:0] mode;
    logic [3:0] hold_value;
    logic       busy;
    logic       step_pulse;
    logic [3:0] cur_pattern;
    logic       mismatch;
    logic [7:0] err_count;

    pio_led_sequencer_if bus();

    pio_led_sequencer #(.TICK_DIV(TICK)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .mode       (mode),
        .hold_value (hold_value),
        .bus        (bus),
        .busy       (busy),
        .step_pulse (step_pulse),
        .cur_pattern(cur_pattern),
        .mismatch   (mismatch),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LED PIO slave model: data bit 2 reads back stuck at 0
    logic [3:0] pio_data;
    logic [3:0] pio_dir;
    initial begin
        pio_data = 4'h0;
        pio_dir  = 4'h0;
        bus.m_readdata = 32'd0;
    end
    always @(posedge clk) begin
        if (bus.m_chipselect && !bus.m_write_n) begin
            case (bus.m_address)
                3'd0: pio_data <= bus.m_writedata[3:0];
                3'd1: pio_dir  <= bus.m_writedata[3:0];
                3'd5: pio_data <= pio_data & ~bus.m_writedata[3:0];
                default: ;
            endcase
        end
        bus.m_readdata <= {28'd0, (bus.m_address == 3'd1) ? pio_dir : (pio_data & STUCK_MASK)};
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] pattern_of(input logic [1:0] md, input int idx, input logic [3:0] hv);
        case (md)
            2'd0:    return 4'(1 << (idx % 4));
            2'd1:    return (idx % 2 == 0) ? 4'hF : 4'h0;
            2'd2:    return 4'(idx % 16);
            default: return hv;
        endcase
    endfunction

    // Reference model: what kind of cycle this is, cycles since the last pattern write, pattern index
    int         m_kind;
    int         m_since;
    int         m_idx;
    logic [1:0] m_last_mode;
    bit         m_restart;
    logic [3:0] m_cur;
    logic [3:0] m_pat;
    bit         m_mm;
    int         m_err;

    task automatic model_reset();
        m_kind      = K_IDLE;
        m_since     = 0;
        m_idx       = 0;
        m_last_mode = 2'd0;
        m_restart   = 1'b1;
        m_cur       = 4'h0;
        m_pat       = 4'h0;
        m_mm        = 1'b0;
        m_err       = 0;
    endtask

    // Per-cycle compare at the falling edge, then advance the model using the inputs about to be sampled
    initial begin
        logic [2:0]  ea;
        logic        ecs;
        logic        ewn;
        logic [31:0] ewd;
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                model_reset();
                continue;
            end
            ea = 3'd0; ecs = 1'b0; ewn = 1'b1; ewd = 32'd0;
            case (m_kind)
                K_DIR: begin
                    ea = 3'd1; ecs = 1'b1; ewn = 1'b0; ewd = 32'hF;
                end
                K_STEP: begin
                    if (m_restart || mode != m_last_mode) m_idx = 0;
                    else m_idx++;
                    m_pat = pattern_of(mode, m_idx, hold_value);
                    ea = 3'd0; ecs = 1'b1; ewn = 1'b0; ewd = {28'd0, m_pat};
                end
                K_RUN: begin
                    if (RB && m_since == 1) begin
                        ea = 3'd0; ecs = 1'b1; ewn = 1'b1;
                    end
                end
                K_CLR: begin
                    ea = 3'd5; ecs = 1'b1; ewn = 1'b0; ewd = 32'hF;
                end
                default: ;
            endcase
            check("bus", {bus.m_address, bus.m_chipselect, bus.m_write_n, bus.m_writedata},
                         {ea, ecs, ewn, ewd});
            check("busy", busy, (m_kind != K_IDLE));
            check("step_pulse", step_pulse, (m_kind == K_STEP));
            check("cur_pattern", cur_pattern, m_cur);
            check("mismatch", mismatch, m_mm);
            check("err_count", err_count, m_err);

            if (m_kind == K_STEP) begin
                m_cur       = m_pat;
                m_last_mode = mode;
                m_restart   = 1'b0;
            end
            if (RB && m_kind == K_RUN && m_since == 2 && (m_cur & STUCK_MASK) != m_cur) begin
                m_mm = 1'b1;
                if (m_err < 255) m_err++;
            end

            case (m_kind)
                K_IDLE: begin
                    if (enable) begin
                        m_kind    = K_DIR;
                        m_restart = 1'b1;
                    end
                end
                K_DIR:  m_kind = K_STEP;
                K_STEP: begin
                    m_kind  = K_RUN;
                    m_since = 1;
                end
                K_RUN: begin
                    if ((!RB || m_since >= 3) && !enable) m_kind = K_CLR;
                    else if (m_since == TICK - 1) m_kind = K_STEP;
                    else m_since++;
                end
                default: m_kind = K_IDLE;
            endcase
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        reset_n    = 1'b0;
        enable     = 1'b1;
        mode       = 2'd0;
        hold_value = 4'h0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Walk from reset release, then binary count past wrap
        run(40);
        mode = 2'd2;
        run(17 * TICK + 12);

        // Walk then a mid-run switch to blink
        mode = 2'd0;
        run(10);
        mode = 2'd1;
        run(14);

        // Hold mode with changing value, then drop enable
        mode = 2'd3;
        hold_value = 4'hA;
        run(9);
        hold_value = 4'h5;
        run(7);
        enable = 1'b0;
        run(10);

        // Random enable/mode/hold activity
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(29) == 0) enable = ~enable;
            if ($urandom_range(24) == 0) mode = 2'($urandom_range(3));
            hold_value = 4'($urandom);
        end

        // Long walk run drives the readback error counter into saturation
        enable = 1'b1;
        mode   = 2'd0;
        run(4400);
        @(negedge clk);
        check("err_sat", err_count, RB ? 8'd255 : 8'd0);
        @(posedge clk);
        #1;

        // Reset in the cycle after a pattern write (readback request slot)
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (step_pulse) found = 1'b1;
        end
        check("step_found", found, 1'b1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("rst_bus", {bus.m_address, bus.m_chipselect, bus.m_write_n, bus.m_writedata},
                         {3'd0, 1'b0, 1'b1, 32'd0});
        check("rst_busy", busy, 1'b0);
        check("rst_step", step_pulse, 1'b0);
        check("rst_cur", cur_pattern, 4'h0);
        check("rst_mm", mismatch, 1'b0);
        check("rst_err", err_count, 8'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        mode = 2'd2;
        run(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pio_led_sequencer.md
# pio_led_sequencer

Autonomous Avalon-MM master that programs the 4-bit LED PIO slave (direction, data, set/clear-bit registers) and steps it through a selectable pattern at a fixed tick rate. It sits between the PIO's slave port and a small control interface (enable, mode, hold value), replacing CPU writes for stand-alone LED animation. It includes optional write-readback checking.

## Interface

- TICK_DIV, 50000000: clk cycles between consecutive pattern writes; legal range 4..2^32-1.
- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run request; level-sensitive.
- mode  in  2  0 walk, 1 blink, 2 binary count, 3 hold.
- hold_value  in  4  pattern used in mode 3.
- m_address  out  3  PIO register address.
- m_chipselect  out  1  PIO chipselect.
- m_write_n  out  1  PIO write strobe, active-low.
- m_writedata  out  32  PIO write data; bits 31:4 always 0.
- m_readdata  in  32  PIO read data; registered by the slave, valid one cycle after address.
- busy  out  1  high in any state other than IDLE.
- step_pulse  out  1  one-cycle pulse in the cycle a pattern write is driven.
- cur_pattern  out  4  last pattern written to address 0.
- mismatch  out  1  sticky readback error (READBACK build only; else constant 0).
- err_count  out  8  saturating readback error count (READBACK build only; else constant 0).

## Operation

- Reset values: m_address 0, m_chipselect 0, m_write_n 1, m_writedata 0, busy 0, step_pulse 0, cur_pattern 0, mismatch 0, err_count 0; state IDLE; period counter 0; pattern generator at first value.
- Bus rule: every write is a single cycle with m_chipselect=1, m_write_n=0; the slave has no waitrequest. All other cycles: m_chipselect=0, m_write_n=1, except readback reads.
- States: IDLE, DIR, STEP, WAIT, RB_REQ, RB_CHK, CLR.
- IDLE: enable=1 -> DIR.
- DIR: write address 1, data 0xF (all pins output) -> STEP.
- STEP: write address 0, data = next pattern; update cur_pattern; step_pulse=1; period counter loads TICK_DIV-1 -> RB_REQ (READBACK) else WAIT.
- RB_REQ: m_address=0, m_chipselect=1, m_write_n=1 -> RB_CHK.
- RB_CHK: compare m_readdata[3:0] with cur_pattern; on mismatch set mismatch, increment err_count (saturate at 255) -> WAIT.
- WAIT: period counter decrements each cycle, including RB cycles; at counter=1 and enable=1 -> STEP; any cycle enable=0 -> CLR.
- CLR: write address 5, data 0xF (clear all data bits) -> IDLE. Direction stays output.
- Patterns: walk 0001,0010,0100,1000, wrap to 0001; blink 1111,0000 alternating, starting 1111; count 0..15 wrap to 0; hold = hold_value sampled in STEP.
- Mode change: detected in STEP (mode differs from mode used at the previous STEP); the first write uses the first value of the new mode.
- enable=0 during DIR, STEP, RB_REQ or RB_CHK: the current state completes, then CLR is entered at the next WAIT evaluation.
- Re-enable restarts from DIR with the pattern at its first value.
- reset_n low mid-operation: all outputs return to reset values immediately. No bus write is completed.

## Timing

- enable sampled high at edge k: DIR write in cycle k+1, first STEP write in cycle k+2.
- STEP-to-STEP spacing is exactly TICK_DIV cycles, independent of READBACK.
- Readback compare occurs 2 cycles after the STEP write.
- enable low sampled in WAIT at edge k: CLR write in cycle k+1, IDLE (busy=0) in cycle k+2.

## Configuration

- PIO_LED_SEQ_READBACK_EN defined: RB_REQ/RB_CHK are compiled in, and mismatch and err_count are live.
- PIO_LED_SEQ_READBACK_EN undefined: STEP goes directly to WAIT, no read cycles are issued, and mismatch and err_count are tied to 0. Write timing is identical in both builds.

## Test plan

- TICK_DIV=4, mode 0, enable at reset release -> writes addr1=0xF, then addr0 = 1,2,4,8,1 spaced 4 cycles; step_pulse is high on each write.
- Mode 2, 17 steps -> writedata 0..15 then 0; cur_pattern tracks; step_pulse count = 17.
- Mode switched 0->1 mid-run -> next write is 0xF, then 0x0.
- Enable dropped in WAIT -> one addr5 write of 0xF next cycle, busy falls the following cycle, no further writes.
- READBACK, PIO model with bit 2 stuck at 0, mode 0 -> mismatch is set after the write of 0x4, and err_count increments once per 4-step cycle up to a 255 cap.
- reset_n pulsed during RB_REQ -> all outputs are at reset values in the same cycle; after release with enable=1, the sequence restarts at DIR.
